// File: rtl/deglitch_sched_pkg.sv
// Shared types and helpers for the round-robin deglitch scheduler.
package deglitch_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } sched_state_t;

  // Keeps index ports at least one bit wide for a single-channel build.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running prescaler: tick is high for one cycle every PRESCALE clocks.
module tick_divider #(
  parameter int PRESCALE = 1000
) (
  input  logic reset,
  input  logic clk,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/deglitch_scan_scheduler.sv
// Time-multiplexed deglitch filter: one shared compare/increment path visits
// each channel once per sample period, with a programmable delay per channel.
module deglitch_scan_scheduler
  import deglitch_sched_pkg::*;
#(
  parameter int NUM_CHANNELS   = 8,
  parameter int PRESCALE       = 1000,
  parameter int DELAY_WIDTH    = 8,
  parameter int DEFAULT_DELAY  = 4,
  parameter bit DEFAULT_OUTPUT = 1'b0
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic [NUM_CHANNELS-1:0]                     in,
  input  logic                                        cfg_we,
  input  logic [idx_width(NUM_CHANNELS)-1:0]          cfg_channel,
  input  logic [DELAY_WIDTH-1:0]                      cfg_delay,
  output logic [NUM_CHANNELS-1:0]                     out,
  output logic [NUM_CHANNELS-1:0]                     changed,
  output logic                                        busy
);

  localparam int IW = idx_width(NUM_CHANNELS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CHANNELS - 1);
  localparam logic [DELAY_WIDTH-1:0] RST_DELAY = DELAY_WIDTH'(DEFAULT_DELAY);

  generate
    if (PRESCALE <= NUM_CHANNELS) begin : g_bad_prescale
      $error("PRESCALE must exceed NUM_CHANNELS so a scan always ends before the next tick");
    end
  endgenerate

  function automatic logic [DELAY_WIDTH-1:0] sat_inc(input logic [DELAY_WIDTH-1:0] v);
    return (&v) ? v : v + DELAY_WIDTH'(1);
  endfunction

  sched_state_t            state, state_nxt;
  logic                    tick;
  logic [IW-1:0]           idx;
  logic [NUM_CHANNELS-1:0] snapshot;
  logic [DELAY_WIDTH-1:0]  cnt     [NUM_CHANNELS];
  logic [DELAY_WIDTH-1:0]  delay_q [NUM_CHANNELS];
  logic                    cfg_ok, scan_en, snap_bit, out_bit;
  logic [DELAY_WIDTH-1:0]  cnt_cur, dly_cur;

  tick_divider #(.PRESCALE(PRESCALE)) u_tick (
    .reset (reset),
    .clk   (clk),
    .tick  (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (tick) state_nxt = SCAN;
      SCAN: if (idx == LAST_IDX) state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SCAN);
  end

  generate
    if ((1 << IW) == NUM_CHANNELS) begin : g_cfg_full
      assign cfg_ok = cfg_we;
    end else begin : g_cfg_range
      assign cfg_ok = cfg_we && (cfg_channel <= LAST_IDX);
    end
  endgenerate

  // Shared datapath: select the channel under scan; a same-cycle cfg write pre-empts it.
  always_comb begin
    snap_bit = snapshot[idx];
    out_bit  = out[idx];
    cnt_cur  = cnt[idx];
    dly_cur  = delay_q[idx];
    scan_en  = busy && !(cfg_ok && (cfg_channel == idx));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out      <= {NUM_CHANNELS{DEFAULT_OUTPUT}};
      changed  <= '0;
      snapshot <= '0;
      idx      <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        cnt[i]     <= '0;
        delay_q[i] <= RST_DELAY;
      end
    end else begin
      changed <= '0;
      if (!busy && tick) begin
        snapshot <= in;
        idx      <= '0;
      end else if (busy) begin
        idx <= (idx == LAST_IDX) ? '0 : idx + IW'(1);
      end

      if (scan_en) begin
        if (snap_bit == out_bit) begin
          cnt[idx] <= '0;
        end else if (cnt_cur >= dly_cur) begin
          out[idx]     <= snap_bit;
          cnt[idx]     <= '0;
          changed[idx] <= 1'b1;
        end else begin
          cnt[idx] <= sat_inc(cnt_cur);
        end
      end

      if (cfg_ok) begin
        delay_q[cfg_channel] <= cfg_delay;
        cnt[cfg_channel]     <= '0;
      end
    end
  end

  a_no_tick_in_scan: assert property (@(posedge clk) disable iff (reset) !(tick && busy));

endmodule

// File: tb/tb_deglitch_scan_scheduler.sv
// Directed bench for deglitch_scan_scheduler with N=8, PRESCALE=16.
module tb_deglitch_scan_scheduler;

  localparam int N  = 8;
  localparam int PS = 16;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  in = '0;
  logic          cfg_we = 1'b0;
  logic [2:0]    cfg_channel = '0;
  logic [DW-1:0] cfg_delay = '0;
  logic [N-1:0]  out, changed;
  logic          busy;

  int errors = 0;
  int checks = 0;
  int ecount;

  deglitch_scan_scheduler #(
    .NUM_CHANNELS(N), .PRESCALE(PS), .DELAY_WIDTH(DW),
    .DEFAULT_DELAY(4), .DEFAULT_OUTPUT(1'b0)
  ) dut (
    .clk(clk), .reset(reset), .in(in), .cfg_we(cfg_we),
    .cfg_channel(cfg_channel), .cfg_delay(cfg_delay),
    .out(out), .changed(changed), .busy(busy)
  );

  always #5 clk = ~clk;

  // Edges since reset release; edge n is the n-th rising edge with reset low.
  always @(posedge clk or posedge reset) begin
    if (reset) ecount <= 0;
    else       ecount <= ecount + 1;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic wait_until(input int n);
    while (ecount < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1; in = '0; cfg_we = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in = '0; cfg_we = 1'b0;
    @(posedge clk); #1;
    checks++; if (out !== 8'h00) begin errors++; $display("FAIL reset_out got=%h exp=00", out); end
    checks++; if (changed !== 8'h00) begin errors++; $display("FAIL reset_changed got=%h exp=00", changed); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      logic exp_busy;
      wait_until(e);
      exp_busy = (e >= 16) && ((e % 16) < 8);
      checks++;
      if (busy !== exp_busy) begin
        errors++; $display("FAIL busy_schedule edge=%0d got=%b exp=%b", e, busy, exp_busy);
      end
      if (e == 1) begin
        checks++;
        if (changed !== 8'h00) begin errors++; $display("FAIL changed_after_reset got=%h exp=00", changed); end
      end
    end
    checks++; if (out !== 8'h00) begin errors++; $display("FAIL idle_out got=%h exp=00", out); end
  endtask

  task automatic test_step();
    apply_reset();
    in[3] = 1'b1;
    wait_until(83);
    checks++; if (out !== 8'h00) begin errors++; $display("FAIL step_before got=%h exp=00", out); end
    wait_until(84);
    checks++; if (out !== 8'h08) begin errors++; $display("FAIL step_out got=%h exp=08", out); end
    checks++; if (changed !== 8'h08) begin errors++; $display("FAIL step_changed got=%h exp=08", changed); end
    wait_until(85);
    checks++; if (changed !== 8'h00) begin errors++; $display("FAIL step_pulse_end got=%h exp=00", changed); end
    checks++; if (out !== 8'h08) begin errors++; $display("FAIL step_hold got=%h exp=08", out); end
  endtask

  task automatic test_glitch();
    apply_reset();
    in[5] = 1'b1;
    wait_until(50);
    in[5] = 1'b0;
    wait_until(70);
    in[5] = 1'b1;
    wait_until(79);
    checks++; if (out !== 8'h00) begin errors++; $display("FAIL glitch_filtered got=%h exp=00", out); end
    wait_until(149);
    checks++; if (out !== 8'h00) begin errors++; $display("FAIL glitch_count_cleared got=%h exp=00", out); end
    wait_until(150);
    checks++; if (out !== 8'h20) begin errors++; $display("FAIL glitch_late_rise got=%h exp=20", out); end
    checks++; if (changed !== 8'h20) begin errors++; $display("FAIL glitch_changed got=%h exp=20", changed); end
  endtask

  task automatic test_cfg_during_scan();
    apply_reset();
    in[2] = 1'b1;
    wait_until(18);
    cfg_we = 1'b1; cfg_channel = 3'd2; cfg_delay = 8'd0;
    wait_until(19);
    cfg_we = 1'b0;
    checks++; if (out !== 8'h00) begin errors++; $display("FAIL cfg_no_change got=%h exp=00", out); end
    checks++; if (changed !== 8'h00) begin errors++; $display("FAIL cfg_no_pulse got=%h exp=00", changed); end
    wait_until(34);
    checks++; if (out !== 8'h00) begin errors++; $display("FAIL cfg_wait got=%h exp=00", out); end
    wait_until(35);
    checks++; if (out !== 8'h04) begin errors++; $display("FAIL cfg_delay0_follow got=%h exp=04", out); end
    checks++; if (changed !== 8'h04) begin errors++; $display("FAIL cfg_delay0_changed got=%h exp=04", changed); end
  endtask

  task automatic test_reset_mid_scan();
    apply_reset();
    for (int c = 0; c < N; c++) begin
      cfg_we = 1'b1; cfg_channel = 3'(c); cfg_delay = 8'd0;
      wait_until(c + 1);
    end
    cfg_we = 1'b0;
    in = 8'hff;
    wait_until(20);
    checks++; if (out !== 8'h0f) begin errors++; $display("FAIL midscan_partial got=%h exp=0f", out); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midscan_busy got=%b exp=1", busy); end
    #2 reset = 1'b1;
    #1;
    checks++; if (out !== 8'h00) begin errors++; $display("FAIL midscan_reset_out got=%h exp=00", out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midscan_reset_busy got=%b exp=0", busy); end
    checks++; if (changed !== 8'h00) begin errors++; $display("FAIL midscan_reset_changed got=%h exp=00", changed); end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    wait_until(1);
    checks++; if (changed !== 8'h00) begin errors++; $display("FAIL midscan_post_changed got=%h exp=00", changed); end
    wait_until(15);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midscan_restart_early got=%b exp=0", busy); end
    wait_until(16);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midscan_restart got=%b exp=1", busy); end
    wait_until(17);
    checks++; if (out !== 8'h00) begin errors++; $display("FAIL midscan_delay_restored got=%h exp=00", out); end
    in = '0;
  endtask

  task automatic test_saturate();
    int pulses;
    apply_reset();
    cfg_we = 1'b1; cfg_channel = 3'd1; cfg_delay = 8'd255;
    in[1] = 1'b1;
    wait_until(1);
    cfg_we = 1'b0;
    pulses = 0;
    for (int e = 2; e <= 300 * PS; e++) begin
      wait_until(e);
      if (changed[1]) pulses++;
      if (e == 4097) begin
        checks++;
        if (out !== 8'h00) begin errors++; $display("FAIL sat_before got=%h exp=00", out); end
      end
      if (e == 4098) begin
        checks++;
        if (out !== 8'h02) begin errors++; $display("FAIL sat_toggle got=%h exp=02", out); end
      end
    end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL sat_single_toggle got=%0d exp=1", pulses); end
    checks++; if (out !== 8'h02) begin errors++; $display("FAIL sat_final got=%h exp=02", out); end
  endtask

  initial begin
    test_reset();
    test_step();
    test_glitch();
    test_cfg_during_scan();
    test_reset_mid_scan();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
